axi_repair_scheduler: RTL and testbench
=======================================

Name: axi_repair_scheduler

Overview:
- Sequencer in front of axi_autorepair: queues repair jobs (one length each) from host/control logic and runs them back to back.
- Per job: latches the length, raises op_start (resets the beat counter), raises autorepair_start, then waits for autorepair_done to fall and rise again.
- axi_autorepair edge-detects both start inputs through a two-flop synchroniser, so this block drives them as held levels, never single-cycle pulses.

Parameters:
- DEPTH, 4: job FIFO entries; power of 2, minimum 2.
- PULSE_W, 4: cycles op_start / autorepair_start are held high; minimum 3.
- GAP_CYC, 8: idle cycles after a job before the next pop; minimum 1.
- TIMEOUT_CYC, 1048576: watchdog limit (cycles) per job; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  job request valid.
- req_ready  out  1  job FIFO not full.
- req_length  in  32  job length; forwarded unchanged.
- length  out  32  length to axi_autorepair.
- op_start  out  1  level start to axi_autorepair.
- autorepair_start  out  1  level start to axi_autorepair.
- autorepair_done  in  1  from axi_autorepair; 1 = idle/finished.
- busy  out  1  high from pop until GAP ends.
- jobs_done  out  16  completed-job counter; wraps at 0xFFFF to 0.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset values: op_start=0, autorepair_start=0, length=0, busy=0, jobs_done=0, err_timeout=0, FIFO empty, state IDLE. Reset mid-job aborts immediately; the queue is lost.
- FIFO: push on req_valid&&req_ready; req_ready = !full, combinational from the registered count. Push while full is impossible. Push and pop in the same cycle are both performed; the count is unchanged. Data is written in order; no bypass.
- IDLE: if FIFO not empty, pop. The next cycle goes to START with length <= head entry and busy=1.
- START: op_start=1 for exactly PULSE_W cycles, then 0. Go to ARM.
- ARM: autorepair_start=1 for exactly PULSE_W cycles, then 0. Go to WAIT_LOW.
- WAIT_LOW: wait until autorepair_done==0, then go to WAIT_DONE. If done never falls, the job hangs; only the watchdog recovers.
- WAIT_DONE: wait until autorepair_done==1. Then jobs_done+1 and go to GAP.
- GAP: GAP_CYC cycles with all strobes low, then IDLE; busy=0 on entering IDLE.
- length is held constant from START through GAP. It changes only on the cycle after a pop.
- op_start and autorepair_start are never high in the same cycle. Both are low for at least GAP_CYC+1 cycles between jobs, so each rising edge is seen by the downstream edge detector.
- Zero length is accepted and run normally; downstream transfers one beat.
- Latency, idle queue to op_start rising: push cycle +1 (FIFO not empty) +1 (pop/latch) = op_start high 2 cycles after the push.

Optional Feature:
- Macro: REPAIR_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counter clears on entering WAIT_LOW and counts in WAIT_LOW and WAIT_DONE.
  - Reaching TIMEOUT_CYC sets err_timeout (sticky, cleared only by rst) and jumps to GAP without incrementing jobs_done.
  - The queue keeps draining.
- Undefined: no watchdog logic; err_timeout tied 0; WAIT states wait forever.

Test Plan:
- Single job: push length=0x10 on an idle queue, downstream model done falls 3 cycles after autorepair_start rises and rises after 9 beats -> op_start high 4 cycles from 2 cycles after push; then autorepair_start high 4 cycles; jobs_done=1; busy low 8 cycles after done rises.
- Back-to-back: push 3 jobs (0x4, 0x8, 0x0) in consecutive cycles -> three START/ARM sequences in order; length output 0x4, 0x8, 0x0; each separated by ≥9 low cycles; jobs_done=3.
- Full FIFO: push 5 jobs while the first is stalled in WAIT_DONE (DEPTH=4) -> req_ready=0 after the 4th queued entry; 5th held until a pop; then accepted and run last.
- Simultaneous push/pop: push exactly in the IDLE pop cycle with 1 entry queued -> count stays 1; no entry lost or duplicated.
- Reset mid-job: assert rst during ARM -> all outputs 0 next cycle; queue empty; jobs_done=0.
- REPAIR_TIMEOUT_EN with TIMEOUT_CYC=100, done stuck at 1 -> err_timeout=1 at 100 cycles into WAIT_LOW; jobs_done unchanged; next queued job still starts after GAP.

Source files
------------

// File: rtl/axi_repair_scheduler_if.sv
// Purpose: bundles the job-request handshake and the axi_autorepair control
//          lines of axi_repair_scheduler into one interface.
// Ports:   req_valid/req_ready/req_length (job queue), length/op_start/
//          autorepair_start/autorepair_done (downstream), busy/jobs_done/
//          err_timeout (status). slave = scheduler side, master = environment.
interface axi_repair_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_length;
  logic [31:0] length;
  logic        op_start;
  logic        autorepair_start;
  logic        autorepair_done;
  logic        busy;
  logic [15:0] jobs_done;
  logic        err_timeout;

  modport slave (
    input  req_valid, req_length, autorepair_done,
    output req_ready, length, op_start, autorepair_start, busy, jobs_done,
           err_timeout
  );

  modport master (
    output req_valid, req_length, autorepair_done,
    input  req_ready, length, op_start, autorepair_start, busy, jobs_done,
           err_timeout
  );
endinterface

// File: rtl/axi_repair_scheduler.sv
// Purpose: queues repair jobs (one length each) and sequences axi_autorepair
//          through op_start / autorepair_start level pulses, one job at a time.
// Latency: op_start rises 2 cycles after a push into an idle, empty queue.
// Backpressure: req_ready = !full (from registered count); no bypass path.
// Ports: clk, rst (sync, active-high); bus (slave modport): req_valid/
//        req_ready/req_length in, length/op_start/autorepair_start out,
//        autorepair_done in, busy/jobs_done/err_timeout status out.
// Option: define REPAIR_TIMEOUT_EN to add the per-job watchdog (TIMEOUT_CYC);
//         without it err_timeout is tied low and the wait states never expire.
module axi_repair_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PULSE_W     = 4,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_repair_scheduler_if.slave bus
);
  localparam int unsigned     AW         = $clog2(DEPTH);
  localparam int unsigned     CW         = 16;
  localparam logic [AW:0]     FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]   PULSE_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0]   GAP_LAST   = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_ARM, ST_WAIT_LOW, ST_WAIT_DONE, ST_GAP
  } state_t;

  // Job FIFO
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ready;
  logic          push;
  logic          pop;

  // Sequencer
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   length_q, length_d;
  logic [15:0]   jobs_q, jobs_d;

`ifdef REPAIR_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  assign ready = (count_q != FULL_CNT);
  assign push  = bus.req_valid && ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.req_length;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leave the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    length_d = length_q;
    jobs_d   = jobs_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Pop looks at the registered count only, so a job pushed this
        // cycle is never started before it has been written.
        if (count_q != '0) begin
          pop      = 1'b1;
          length_d = mem_q[rd_ptr_q];
          state_d  = ST_START;
          cnt_d    = '0;
        end
      end
      ST_START: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ARM: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOW: begin
        // done must be seen low first so a stale "idle" level from the
        // previous job is not taken as completion.
        if (!bus.autorepair_done) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.autorepair_done) begin
          jobs_d  = jobs_q + 16'd1;
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef REPAIR_TIMEOUT_EN
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == ST_ARM) begin
      // Held at zero while arming, so it starts from zero in WAIT_LOW.
      wd_d = '0;
    end else if (state_q == ST_WAIT_LOW || state_q == ST_WAIT_DONE) begin
      wd_d = wd_q + 32'd1;
      // A completion seen in the same cycle takes precedence.
      if (wd_q == WD_LAST && state_d != ST_GAP) begin
        err_d   = 1'b1;
        state_d = ST_GAP;
        cnt_d   = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      length_q <= '0;
      jobs_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      length_q <= length_d;
      jobs_q   <= jobs_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef REPAIR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign bus.err_timeout = err_q;
`else
  localparam int unsigned timeout_unused = TIMEOUT_CYC;
  assign bus.err_timeout = 1'b0;
`endif

  // Strobes are decoded straight from the state register: glitch-free,
  // mutually exclusive, and held for whole states.
  assign bus.req_ready        = ready;
  assign bus.length           = length_q;
  assign bus.op_start         = (state_q == ST_START);
  assign bus.autorepair_start = (state_q == ST_ARM);
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.jobs_done        = jobs_q;
endmodule

// File: tb/tb_axi_repair_scheduler.sv
module tb_axi_repair_scheduler;
  localparam int DEPTH = 4;
  localparam int PW    = 4;
  localparam int GAP   = 8;
  localparam int TO    = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_repair_scheduler_if bus();

  axi_repair_scheduler #(
    .DEPTH(DEPTH), .PULSE_W(PW), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- downstream axi_autorepair stand-in ----------------
  bit resp_en   = 1'b1;
  int resp_fall = 3;   // cycles from autorepair_start rise to done falling
  int resp_hold = 9;   // cycles done stays low

  initial begin
    int   ph;
    int   k;
    logic ars_prev;
    ph = 0; k = 0; ars_prev = 1'b0;
    bus.autorepair_done = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.autorepair_done = 1'b1;
        ph = 0;
      end else begin
        case (ph)
          0: if (resp_en && bus.autorepair_start && !ars_prev) begin ph = 1; k = resp_fall; end
          1: begin
            k--;
            if (k == 0) begin bus.autorepair_done = 1'b0; ph = 2; k = resp_hold; end
          end
          default: begin
            k--;
            if (k == 0) begin bus.autorepair_done = 1'b1; ph = 0; end
          end
        endcase
      end
      ars_prev = bus.autorepair_start;
    end
  end

  // ---------------- job-timeline model + per-cycle compare ----------------
  // Each job is a timeline anchored at its first op_start cycle t_start:
  // op_start over [t_start, t_start+PW), autorepair_start over the next PW
  // cycles, waiting from t_start+2*PW, then GAP idle cycles after the
  // completing cycle. A job starts the cycle after an idle cycle that finds
  // the queue non-empty.
  logic [31:0] m_q[$];
  logic [31:0] seen_q[$];

  function automatic logic [31:0] seen_at(input int i);
    if (i < seen_q.size()) return seen_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    longint s, t_start, t_done;
    bit     job_valid, low_seen, act, e_op, e_ars, m_err;
    logic [31:0] m_len;
    logic [15:0] m_jobs;
    logic        op_prev;
    s = 0; t_start = 0; t_done = -1; job_valid = 0; low_seen = 0;
    m_err = 0; m_len = '0; m_jobs = '0; op_prev = 1'b0;
    forever begin
      @(negedge clk);
      s++;
      if (rst) begin
        job_valid = 0; m_q.delete(); m_len = '0; m_jobs = '0; m_err = 0; op_prev = 1'b0;
      end else begin
        act   = job_valid && (t_done < 0 || s <= t_done + GAP);
        e_op  = job_valid && s >= t_start && s < t_start + PW;
        e_ars = job_valid && s >= t_start + PW && s < t_start + 2*PW;
        chk("mon_op_start", 32'(bus.op_start), 32'(e_op));
        chk("mon_autorepair_start", 32'(bus.autorepair_start), 32'(e_ars));
        chk("mon_busy", 32'(bus.busy), 32'(act));
        chk("mon_length", bus.length, m_len);
        chk("mon_jobs_done", 32'(bus.jobs_done), 32'(m_jobs));
        chk("mon_err_timeout", 32'(bus.err_timeout), 32'(m_err));
        chk("mon_req_ready", 32'(bus.req_ready), 32'(m_q.size() < DEPTH));

        if (bus.op_start && !op_prev) seen_q.push_back(bus.length);
        op_prev = bus.op_start;

        if (job_valid && t_done < 0 && s >= t_start + 2*PW) begin
          if (low_seen && bus.autorepair_done) begin
            t_done = s;
            m_jobs = m_jobs + 16'd1;
          end
`ifdef REPAIR_TIMEOUT_EN
          else if (s - (t_start + 2*PW) == TO - 1) begin
            t_done = s;
            m_err  = 1;
          end
`endif
          else if (!bus.autorepair_done) begin
            low_seen = 1;
          end
        end

        if (!act && m_q.size() > 0) begin
          job_valid = 1; t_start = s + 1; t_done = -1; low_seen = 0;
          m_len = m_q.pop_front();
        end
        if (bus.req_valid && bus.req_ready) m_q.push_back(bus.req_length);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.op_start;
      1:       return bus.autorepair_start;
      2:       return bus.autorepair_done;
      3:       return bus.busy;
      default: return bus.err_timeout;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int sel, input logic val,
                          input int budget, output int n);
    n = 0;
    while (sig(sel) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: wait expired after %0d cycles, required level %0b", nm, budget, val);
    end
  endtask

  task automatic wait_jobs(input string nm, input int target, input int budget);
    int n;
    n = 0;
    while (32'(bus.jobs_done) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: jobs_done=%0d after %0d cycles, required %0d", nm, bus.jobs_done, budget, target);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic push(input logic [31:0] l);
    int n;
    n = 0;
    bus.req_valid  = 1'b1;
    bus.req_length = l;
    @(negedge clk);
    while (!bus.req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL push_accept: 0x%0h not accepted in 500 cycles, required req_ready=1", l);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_length = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_op_start", 32'(bus.op_start), 32'd0);
    chk("rst_ars", 32'(bus.autorepair_start), 32'd0);
    chk("rst_length", bus.length, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_jobs_done", 32'(bus.jobs_done), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // Single job, cycle-exact (push accepted in cycle P)
    push(32'h10);
    @(negedge clk);               chk("t1_op_p1", 32'(bus.op_start), 32'd0);
    @(negedge clk);               chk("t1_op_p2", 32'(bus.op_start), 32'd1);
                                  chk("t1_len_p2", bus.length, 32'h10);
                                  chk("t1_busy_p2", 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clk);    chk("t1_op_p5", 32'(bus.op_start), 32'd1);
    @(negedge clk);               chk("t1_op_p6", 32'(bus.op_start), 32'd0);
                                  chk("t1_ars_p6", 32'(bus.autorepair_start), 32'd1);
    repeat (3) @(negedge clk);    chk("t1_ars_p9", 32'(bus.autorepair_start), 32'd1);
    @(negedge clk);               chk("t1_ars_p10", 32'(bus.autorepair_start), 32'd0);
    wait_for("t1_done_rise", 2, 1'b1, 100, n);
    chk("t1_jobs_before", 32'(bus.jobs_done), 32'd0);
    @(negedge clk);               chk("t1_jobs_after", 32'(bus.jobs_done), 32'd1);
    wait_for("t1_busy_fall", 3, 1'b0, 50, n);
    chk("t1_busy_fall_delay", 32'(n), 32'd8);
    @(posedge clk); #1;

    // Back-to-back jobs
    do_reset();
    push(32'h4); push(32'h8); push(32'h0);
    wait_jobs("t2_jobs", 3, 1000);
    @(negedge clk);
    chk("t2_count", 32'(seen_q.size()), 32'd3);
    chk("t2_len0", seen_at(0), 32'h4);
    chk("t2_len1", seen_at(1), 32'h8);
    chk("t2_len2", seen_at(2), 32'h0);
    chk("t2_jobs_done", 32'(bus.jobs_done), 32'd3);
    @(posedge clk); #1;

    // Full FIFO while the first job stalls in WAIT_DONE
    do_reset();
    resp_hold = 60;
    push(32'h21);
    wait_for("t3_stall", 2, 1'b0, 100, n);
    @(posedge clk); #1;
    push(32'h22); push(32'h23); push(32'h24); push(32'h25);
    @(negedge clk);
    chk("t3_ready_full", 32'(bus.req_ready), 32'd0);
    chk("t3_jobs_stalled", 32'(bus.jobs_done), 32'd0);
    @(posedge clk); #1;
    push(32'h26);
    wait_jobs("t3_jobs", 6, 3000);
    @(negedge clk);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_len%0d", i), seen_at(i), 32'h21 + 32'(i));
    resp_hold = 9;
    @(posedge clk); #1;

    // Push exactly in the pop cycle
    do_reset();
    push(32'h31); push(32'h32);
    wait_jobs("t4_jobs", 2, 500);
    repeat (30) @(negedge clk);
    chk("t4_count", 32'(seen_q.size()), 32'd2);
    chk("t4_len0", seen_at(0), 32'h31);
    chk("t4_len1", seen_at(1), 32'h32);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_jobs_done", 32'(bus.jobs_done), 32'd2);
    @(posedge clk); #1;

    // Reset during ARM with one job still queued
    push(32'h41); push(32'h42);
    wait_for("t5_arm", 1, 1'b1, 100, n);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_op_start", 32'(bus.op_start), 32'd0);
    chk("t5_ars", 32'(bus.autorepair_start), 32'd0);
    chk("t5_length", bus.length, 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_jobs_done", 32'(bus.jobs_done), 32'd0);
    chk("t5_err", 32'(bus.err_timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_q.delete();
    repeat (20) @(negedge clk);
    chk("t5_queue_lost", 32'(seen_q.size()), 32'd0);
    chk("t5_idle", 32'(bus.busy), 32'd0);
    chk("t5_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

`ifdef REPAIR_TIMEOUT_EN
    // Watchdog with done stuck high
    do_reset();
    resp_en = 1'b0;
    push(32'h51); push(32'h52);
    wait_for("t6_arm", 1, 1'b1, 50, n);
    wait_for("t6_wait_low", 1, 1'b0, 50, n);
    wait_for("t6_err", 4, 1'b1, 300, n);
    chk("t6_err_delay", 32'(n), 32'd100);
    chk("t6_jobs_done", 32'(bus.jobs_done), 32'd0);
    wait_for("t6_next_start", 0, 1'b1, 50, n);
    chk("t6_next_len", bus.length, 32'h52);
    wait_for("t6_drain", 3, 1'b0, 300, n);
    chk("t6_jobs_final", 32'(bus.jobs_done), 32'd0);
    chk("t6_err_sticky", 32'(bus.err_timeout), 32'd1);
    resp_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_watchdog: simulation did not complete, required completion before 1 ms");
    $fatal(1, "global watchdog expired");
  end
endmodule
